tcp_tx_hdr_arb: RTL and testbench

- Arbitrates two TCP TX header sources onto the single parser TX interface (tcp_parser_tx_*):
  - Source 0: SYN-ACK generator from the receive pipe.
  - Source 1: app/engine header sender.
- SYN-ACK is preferred. A consecutive-grant limit guarantees the app source cannot be starved.
- The output is a registered single-entry slice, so parser-side timing is decoupled from both sources.
- Sits between recv_pipe_wrap/app and the parser, and replaces ad-hoc fixed-priority muxing.

---
 rtl/tcp_tx_hdr_arb.sv | 140 ++++++++++++++
 tb/tb_tcp_tx_hdr_arb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_tx_hdr_arb.sv
// Two-source TCP TX header arbiter with a registered single-entry output slice.
// Optional statistics counters are compiled in with TCP_TX_ARB_STATS_EN.

`ifndef IP_ADDR_WIDTH
`define IP_ADDR_WIDTH 32
`endif
`ifndef TCP_HEADER_WIDTH
`define TCP_HEADER_WIDTH 160
`endif
`ifndef PAYLOAD_BUF_ENTRY_ADDR_WIDTH
`define PAYLOAD_BUF_ENTRY_ADDR_WIDTH 16
`endif
`ifndef PAYLOAD_BUF_ENTRY_LEN_WIDTH
`define PAYLOAD_BUF_ENTRY_LEN_WIDTH 16
`endif

module tcp_tx_hdr_arb #(
  parameter int unsigned SYN_BURST_MAX = 4,
  parameter int unsigned STREAK_W      = $clog2(SYN_BURST_MAX + 1)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,

  input  logic                                     syn_ack_val,
  output logic                                     syn_ack_rdy,
  input  logic [`IP_ADDR_WIDTH-1:0]                syn_ack_src_ip,
  input  logic [`IP_ADDR_WIDTH-1:0]                syn_ack_dst_ip,
  input  logic [`TCP_HEADER_WIDTH-1:0]             syn_ack_hdr,

  input  logic                                     app_tx_val,
  output logic                                     app_tx_rdy,
  input  logic [`IP_ADDR_WIDTH-1:0]                app_tx_src_ip,
  input  logic [`IP_ADDR_WIDTH-1:0]                app_tx_dst_ip,
  input  logic [`TCP_HEADER_WIDTH-1:0]             app_tx_hdr,
  input  logic [`PAYLOAD_BUF_ENTRY_ADDR_WIDTH-1:0] app_tx_payload_addr,
  input  logic [`PAYLOAD_BUF_ENTRY_LEN_WIDTH-1:0]  app_tx_payload_len,

  output logic                                     tcp_parser_tx_val,
  input  logic                                     parser_tcp_tx_rdy,
  output logic [`IP_ADDR_WIDTH-1:0]                tcp_parser_tx_src_ip,
  output logic [`IP_ADDR_WIDTH-1:0]                tcp_parser_tx_dst_ip,
  output logic [`TCP_HEADER_WIDTH-1:0]             tcp_parser_tx_tcp_hdr,
  output logic [`PAYLOAD_BUF_ENTRY_ADDR_WIDTH-1:0] tcp_parser_tx_payload_addr,
  output logic [`PAYLOAD_BUF_ENTRY_LEN_WIDTH-1:0]  tcp_parser_tx_payload_len,
  output logic                                     tcp_parser_tx_src
`ifdef TCP_TX_ARB_STATS_EN
  ,
  output logic [31:0]                              stat_syn_grants,
  output logic [31:0]                              stat_app_grants,
  output logic [31:0]                              stat_forced_app
`endif
);

  localparam logic [STREAK_W-1:0] BURST_MAX = STREAK_W'(SYN_BURST_MAX);

  logic                load_en;
  logic                grant0;
  logic                grant1;
  logic                burst_full;
  logic [STREAK_W-1:0] streak;

  assign load_en    = ~tcp_parser_tx_val | parser_tcp_tx_rdy;
  assign burst_full = (streak == BURST_MAX);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (load_en) begin
      if (syn_ack_val && app_tx_val) begin
        grant1 = burst_full;
        grant0 = ~burst_full;
      end else begin
        grant0 = syn_ack_val;
        grant1 = app_tx_val;
      end
    end
  end

  assign syn_ack_rdy = grant0;
  assign app_tx_rdy  = grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcp_parser_tx_val          <= 1'b0;
      tcp_parser_tx_src          <= 1'b0;
      tcp_parser_tx_src_ip       <= '0;
      tcp_parser_tx_dst_ip       <= '0;
      tcp_parser_tx_tcp_hdr      <= '0;
      tcp_parser_tx_payload_addr <= '0;
      tcp_parser_tx_payload_len  <= '0;
    end else if (load_en) begin
      if (grant0) begin
        tcp_parser_tx_val          <= 1'b1;
        tcp_parser_tx_src          <= 1'b0;
        tcp_parser_tx_src_ip       <= syn_ack_src_ip;
        tcp_parser_tx_dst_ip       <= syn_ack_dst_ip;
        tcp_parser_tx_tcp_hdr      <= syn_ack_hdr;
        tcp_parser_tx_payload_addr <= '0;
        tcp_parser_tx_payload_len  <= '0;
      end else if (grant1) begin
        tcp_parser_tx_val          <= 1'b1;
        tcp_parser_tx_src          <= 1'b1;
        tcp_parser_tx_src_ip       <= app_tx_src_ip;
        tcp_parser_tx_dst_ip       <= app_tx_dst_ip;
        tcp_parser_tx_tcp_hdr      <= app_tx_hdr;
        tcp_parser_tx_payload_addr <= app_tx_payload_addr;
        tcp_parser_tx_payload_len  <= app_tx_payload_len;
      end else begin
        tcp_parser_tx_val <= 1'b0;
      end
    end
  end

  // Streak only counts SYN-ACK wins that actually made the app source wait;
  // a grant 0 with app waiting implies streak < max, so no saturation needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (!app_tx_val || grant1) begin
      streak <= '0;
    end else if (grant0) begin
      streak <= streak + 1'b1;
    end
  end

`ifdef TCP_TX_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_syn_grants <= '0;
      stat_app_grants <= '0;
      stat_forced_app <= '0;
    end else begin
      if (grant0) stat_syn_grants <= stat_syn_grants + 32'd1;
      if (grant1) stat_app_grants <= stat_app_grants + 32'd1;
      if (grant1 && syn_ack_val && burst_full) stat_forced_app <= stat_forced_app + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tcp_tx_hdr_arb.sv
// Bench for tcp_tx_hdr_arb: queue-free reference model of the arbitration rules
// checked every cycle, plus directed scenarios with literal expectations.

`ifndef IP_ADDR_WIDTH
`define IP_ADDR_WIDTH 32
`endif
`ifndef TCP_HEADER_WIDTH
`define TCP_HEADER_WIDTH 160
`endif
`ifndef PAYLOAD_BUF_ENTRY_ADDR_WIDTH
`define PAYLOAD_BUF_ENTRY_ADDR_WIDTH 16
`endif
`ifndef PAYLOAD_BUF_ENTRY_LEN_WIDTH
`define PAYLOAD_BUF_ENTRY_LEN_WIDTH 16
`endif

module tb_tcp_tx_hdr_arb;

  localparam int unsigned BURST = 4;
  localparam int IPW = `IP_ADDR_WIDTH;
  localparam int HW  = `TCP_HEADER_WIDTH;
  localparam int AW  = `PAYLOAD_BUF_ENTRY_ADDR_WIDTH;
  localparam int LW  = `PAYLOAD_BUF_ENTRY_LEN_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          syn_ack_val, syn_ack_rdy;
  logic [IPW-1:0] syn_ack_src_ip, syn_ack_dst_ip;
  logic [HW-1:0]  syn_ack_hdr;
  logic          app_tx_val, app_tx_rdy;
  logic [IPW-1:0] app_tx_src_ip, app_tx_dst_ip;
  logic [HW-1:0]  app_tx_hdr;
  logic [AW-1:0]  app_tx_payload_addr;
  logic [LW-1:0]  app_tx_payload_len;
  logic          tcp_parser_tx_val, parser_tcp_tx_rdy;
  logic [IPW-1:0] tcp_parser_tx_src_ip, tcp_parser_tx_dst_ip;
  logic [HW-1:0]  tcp_parser_tx_tcp_hdr;
  logic [AW-1:0]  tcp_parser_tx_payload_addr;
  logic [LW-1:0]  tcp_parser_tx_payload_len;
  logic          tcp_parser_tx_src;
`ifdef TCP_TX_ARB_STATS_EN
  logic [31:0]   stat_syn_grants, stat_app_grants, stat_forced_app;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tcp_tx_hdr_arb #(.SYN_BURST_MAX(BURST)) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .syn_ack_val                (syn_ack_val),
    .syn_ack_rdy                (syn_ack_rdy),
    .syn_ack_src_ip             (syn_ack_src_ip),
    .syn_ack_dst_ip             (syn_ack_dst_ip),
    .syn_ack_hdr                (syn_ack_hdr),
    .app_tx_val                 (app_tx_val),
    .app_tx_rdy                 (app_tx_rdy),
    .app_tx_src_ip              (app_tx_src_ip),
    .app_tx_dst_ip              (app_tx_dst_ip),
    .app_tx_hdr                 (app_tx_hdr),
    .app_tx_payload_addr        (app_tx_payload_addr),
    .app_tx_payload_len         (app_tx_payload_len),
    .tcp_parser_tx_val          (tcp_parser_tx_val),
    .parser_tcp_tx_rdy          (parser_tcp_tx_rdy),
    .tcp_parser_tx_src_ip       (tcp_parser_tx_src_ip),
    .tcp_parser_tx_dst_ip       (tcp_parser_tx_dst_ip),
    .tcp_parser_tx_tcp_hdr      (tcp_parser_tx_tcp_hdr),
    .tcp_parser_tx_payload_addr (tcp_parser_tx_payload_addr),
    .tcp_parser_tx_payload_len  (tcp_parser_tx_payload_len),
    .tcp_parser_tx_src          (tcp_parser_tx_src)
`ifdef TCP_TX_ARB_STATS_EN
    ,
    .stat_syn_grants            (stat_syn_grants),
    .stat_app_grants            (stat_app_grants),
    .stat_forced_app            (stat_forced_app)
`endif
  );

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the slot holds whatever was last granted; the app source may be
  // passed over by SYN-ACK at most BURST times in a row before it must win.
  logic          m_val, m_src;
  logic [IPW-1:0] m_sip, m_dip;
  logic [HW-1:0]  m_hdr;
  logic [AW-1:0]  m_paddr;
  logic [LW-1:0]  m_plen;
  int unsigned   m_passed_over;

  function automatic logic [1:0] model_grants();
    logic can_load, g0, g1;
    can_load = !m_val || parser_tcp_tx_rdy;
    g0 = can_load && syn_ack_val && !(app_tx_val && m_passed_over >= BURST);
    g1 = can_load && app_tx_val && !(syn_ack_val && m_passed_over < BURST);
    return {g1, g0};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [1:0] g;
    if (!rst_n) begin
      m_val <= 1'b0; m_src <= 1'b0; m_sip <= '0; m_dip <= '0;
      m_hdr <= '0; m_paddr <= '0; m_plen <= '0; m_passed_over <= 0;
    end else begin
      g = model_grants();
      if (g[0]) begin
        m_val <= 1'b1; m_src <= 1'b0; m_sip <= syn_ack_src_ip; m_dip <= syn_ack_dst_ip;
        m_hdr <= syn_ack_hdr; m_paddr <= '0; m_plen <= '0;
      end else if (g[1]) begin
        m_val <= 1'b1; m_src <= 1'b1; m_sip <= app_tx_src_ip; m_dip <= app_tx_dst_ip;
        m_hdr <= app_tx_hdr; m_paddr <= app_tx_payload_addr; m_plen <= app_tx_payload_len;
      end else if (!m_val || parser_tcp_tx_rdy) begin
        m_val <= 1'b0;
      end
      if (!app_tx_val || g[1]) m_passed_over <= 0;
      else if (g[0]) m_passed_over <= m_passed_over + 1;
    end
  end

  // Log of sources popped by the parser, for literal sequence checks.
  logic pop_log [$];

  always @(negedge clk) begin
    logic [1:0] g;
    if (rst_n === 1'b1) begin
      g = model_grants();
      check("syn_ack_rdy", 256'(syn_ack_rdy), 256'(g[0]));
      check("app_tx_rdy", 256'(app_tx_rdy), 256'(g[1]));
      check("out_val", 256'(tcp_parser_tx_val), 256'(m_val));
      if (m_val) begin
        check("out_src", 256'(tcp_parser_tx_src), 256'(m_src));
        check("out_src_ip", 256'(tcp_parser_tx_src_ip), 256'(m_sip));
        check("out_dst_ip", 256'(tcp_parser_tx_dst_ip), 256'(m_dip));
        check("out_hdr", 256'(tcp_parser_tx_tcp_hdr), 256'(m_hdr));
        check("out_paddr", 256'(tcp_parser_tx_payload_addr), 256'(m_paddr));
        check("out_plen", 256'(tcp_parser_tx_payload_len), 256'(m_plen));
      end
      if (tcp_parser_tx_val && parser_tcp_tx_rdy) pop_log.push_back(tcp_parser_tx_src);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [HW-1:0] hdr_a5;
  logic [HW-1:0] snap_hdr;
  logic [IPW-1:0] snap_sip;
  logic          snap_src;
  logic [9:0]    exp_seq;

  initial begin
    rst_n = 1'b0;
    syn_ack_val = 1'b0; syn_ack_src_ip = '0; syn_ack_dst_ip = '0; syn_ack_hdr = '0;
    app_tx_val = 1'b0; app_tx_src_ip = '0; app_tx_dst_ip = '0; app_tx_hdr = '0;
    app_tx_payload_addr = '0; app_tx_payload_len = '0;
    parser_tcp_tx_rdy = 1'b1;
    hdr_a5 = {(HW/8){8'hA5}};

    // Reset state
    repeat (3) tick();
    #1;
    check("rst_val", 256'(tcp_parser_tx_val), 256'd0);
    check("rst_src", 256'(tcp_parser_tx_src), 256'd0);
    check("rst_hdr", 256'(tcp_parser_tx_tcp_hdr), 256'd0);
    check("rst_streak", 256'(dut.streak), 256'd0);
    rst_n = 1'b1;

    // Idle: nothing requested, nothing granted
    repeat (10) tick();
    #1;
    check("idle_val", 256'(tcp_parser_tx_val), 256'd0);
    check("idle_rdys", 256'({syn_ack_rdy, app_tx_rdy}), 256'd0);

    // Single SYN-ACK pulse; app fields dirty to prove payload is zeroed on grant 0
    app_tx_payload_addr = 16'h1234; app_tx_payload_len = 16'h0040;
    syn_ack_val = 1'b1; syn_ack_hdr = hdr_a5;
    syn_ack_src_ip = 32'hC0A8_0001; syn_ack_dst_ip = 32'h0A00_0002;
    tick();
    syn_ack_val = 1'b0;
    #1;
    check("pulse_val", 256'(tcp_parser_tx_val), 256'd1);
    check("pulse_hdr", 256'(tcp_parser_tx_tcp_hdr), 256'(hdr_a5));
    check("pulse_paddr", 256'(tcp_parser_tx_payload_addr), 256'd0);
    check("pulse_plen", 256'(tcp_parser_tx_payload_len), 256'd0);
    check("pulse_src", 256'(tcp_parser_tx_src), 256'd0);
    tick();

    // Contention with parser always ready
    pop_log.delete();
    syn_ack_val = 1'b1; syn_ack_hdr = {(HW/32){32'h5151_0000}};
    app_tx_val = 1'b1; app_tx_hdr = {(HW/32){32'hA9A9_0000}};
    app_tx_src_ip = 32'hAC10_0001; app_tx_dst_ip = 32'hAC10_0002;
    app_tx_payload_addr = 16'h0100; app_tx_payload_len = 16'd32;
    repeat (12) tick();
    exp_seq = 10'b1000010000; // bit i = source of pop i (first pop in bit 0)
    check("seq_len_ok", 256'(pop_log.size() >= 10), 256'd1);
    for (int i = 0; i < 10; i++) begin
      if (i < pop_log.size()) check($sformatf("seq_pop%0d", i), 256'(pop_log[i]), 256'(exp_seq[i]));
    end

    // Stall with both sources pending
    parser_tcp_tx_rdy = 1'b0;
    #1;
    snap_hdr = tcp_parser_tx_tcp_hdr; snap_sip = tcp_parser_tx_src_ip; snap_src = tcp_parser_tx_src;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_val", 256'(tcp_parser_tx_val), 256'd1);
      check("stall_hdr", 256'(tcp_parser_tx_tcp_hdr), 256'(snap_hdr));
      check("stall_sip", 256'(tcp_parser_tx_src_ip), 256'(snap_sip));
      check("stall_src", 256'(tcp_parser_tx_src), 256'(snap_src));
      check("stall_rdys", 256'({syn_ack_rdy, app_tx_rdy}), 256'd0);
    end
    parser_tcp_tx_rdy = 1'b1;
    #1;
    check("unstall_grant", 256'(syn_ack_rdy | app_tx_rdy), 256'd1);
    tick();
    check("unstall_val", 256'(tcp_parser_tx_val), 256'd1);
    syn_ack_val = 1'b0;
    tick();

    // App-only streaming, payload_len 64
    app_tx_payload_len = 16'd64;
    for (int i = 0; i < 8; i++) begin
      app_tx_hdr = HW'(32'hD000_0000 + i);
      tick();
      check("app_val", 256'(tcp_parser_tx_val), 256'd1);
      check("app_src", 256'(tcp_parser_tx_src), 256'd1);
      check("app_plen", 256'(tcp_parser_tx_payload_len), 256'd64);
      check("app_hdr", 256'(tcp_parser_tx_tcp_hdr), 256'(HW'(32'hD000_0000 + i)));
      check("app_streak", 256'(dut.streak), 256'd0);
    end

    // Async reset while an entry is held, with a built-up streak
    syn_ack_val = 1'b1;
    repeat (2) tick();
    check("pre_rst_val", 256'(tcp_parser_tx_val), 256'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_val", 256'(tcp_parser_tx_val), 256'd0);
    check("arst_streak", 256'(dut.streak), 256'd0);
    check("arst_hdr", 256'(tcp_parser_tx_tcp_hdr), 256'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_src", 256'(tcp_parser_tx_src), 256'd0);
    check("post_rst_val", 256'(tcp_parser_tx_val), 256'd1);
    syn_ack_val = 1'b0; app_tx_val = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
